lc3_execute_stage: RTL and testbench
====================================

// Module: lc3_execute_stage
// PURPOSE
//  LC-3 pipeline execute stage, directly downstream of decode. Consumes the
//  decode bundle (w_control, mem_control, e_control, IR, npc_out) and register
//  values, resolves bypass forwarding, and computes the ALU result and the
//  target/effective address. Registers all results one cycle later for the
//  memory-access and writeback stages.
// PARAMETERS
//  DATA_W   16  datapath width (LC-3 word, fixed at 16 in this design)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   synchronous, active-low (0 = reset)
//  enable_execute   in   1   1 = capture new results; 0 = hold all registers
//  e_control        in   6   [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
//  w_control_in     in   2   writeback select from decode, passed through
//  mem_control_in   in   1   memory-access control from decode, passed through
//  IR               in   16  instruction from decode
//  npc_in           in   16  PC+1 from decode (decode's npc_out)
//  VSR1, VSR2       in   16  register-file read data for sr1/sr2
//  bypass_alu_1/2   in   1   replace operand1/2 with the registered aluout
//  bypass_mem_1/2   in   1   replace operand1/2 with mem_bypass_val
//  mem_bypass_val   in   16  forwarded memory-stage data
//  sr1, sr2         out  3   combinational register-file read addresses
//  aluout           out  16  registered ALU result, or address for LEA
//  pcout            out  16  registered address-adder result (branch/jump/load/store)
//  M_Data           out  16  registered store data (operand2 after bypass)
//  dr               out  3   registered destination register, IR[11:9]
//  NZP              out  3   registered IR[11:9] when opcode is BR/JMP; 0 otherwise
//  IR_Exec          out  16  registered copy of IR
//  W_Control_out    out  2   registered w_control_in
//  Mem_Control_out  out  1   registered mem_control_in
// BEHAVIOUR
//  - sr1 = IR[8:6]. sr2 = IR[11:9] for ST/STR/STI, else IR[2:0]. Pure combinational.
//  - Operand1 = bypass_alu_1 ? aluout : bypass_mem_1 ? mem_bypass_val : VSR1.
//    Operand2 is built the same way from the *_2 bypasses. ALU bypass wins
//    when both bypasses are set.
//  - ALU B input = op2select ? operand2 : sext(IR[4:0]).
//  - alu_control: 00 ADD, 01 AND, 10 NOT A (B ignored), 11 pass A.
//  - Address adder: base = pcselect2 ? npc_in : operand1.
//    Offset by pcselect1: 00 sext IR[10:0], 01 sext IR[8:0], 10 sext IR[5:0], 11 zero.
//  - All sums are modulo 2^16. There is no carry or overflow output.
//  - aluout captures the adder result for LEA and the ALU result for every
//    other opcode.
//  - Latency is 1 cycle. With reset=1 and enable_execute=1, all registered
//    outputs load at the rising edge.
//  - enable_execute=0 (stall): all registered outputs hold. Combinational sr1/sr2
//    still track IR.
//  - Reset (reset=0 at a rising edge): every registered output goes to 0.
//    This includes W_Control_out, Mem_Control_out and NZP, so no spurious
//    branch is taken. Reset overrides enable. Reset asserted mid-stream drops
//    the in-flight instruction, with no partial update.
//  - A back-to-back dependency uses the old registered aluout through
//    bypass_alu (register-to-register forwarding). There is no combinational
//    loop from aluout to itself.
// STRUCTURE
//  - Shared package lc3_pkg holds: the opcode enum (ADD=4'h1, AND=4'h5,
//    NOT=4'h9, BR=4'h0, JMP=4'hC, LD, LDR, LDI, LEA=4'hE, ST, STR, STI);
//    localparams for the e_control field positions; the alu_control and
//    w_control enums; and a sext function.
//  - One sub-module, lc3_exec_alu: combinational ALU plus address adder.
//    The top level keeps operand muxing, the pipeline registers and sr decode.
// TESTING
//  1. Reset: hold reset=0 for 2 clocks with random inputs. All registered
//     outputs read 0. NZP=0, W_Control_out=0.
//  2. ADD: IR=16'h1283 (ADD R1,R2,R3), VSR1=5, VSR2=7, e_control=6'b000001,
//     enable=1. Next cycle aluout=12, dr=1. sr1=2, sr2=3 combinationally.
//  3. Immediate and wrap: IR=16'h1261 (ADD R1,R1,#1), VSR1=16'hFFFF,
//     op2select=0. Result aluout=16'h0000.
//  4. Bypass: IR=16'h1283 with bypass_alu_1=1, bypass_mem_1=1,
//     mem_bypass_val=9, previous aluout=12, VSR2=7. Result aluout=19.
//     Repeat with only bypass_mem_1=1: result aluout=16.
//  5. BR/LEA: npc_in=16'h3001, IR=16'h0A05 (BRnp +5), e_control=6'b000110.
//     Result pcout=16'h3006, NZP=3'b101. Then LEA R2,#-1 (IR=16'hE5FF):
//     aluout=16'h3000.
//  6. Stall and reset mid-op: load ADD result 12. Drop enable for 3 cycles
//     while changing inputs: outputs hold 12. Assert reset=0 with enable=1:
//     next edge all outputs are 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, control encodings and helpers shared by the LC-3 execute stage.
package lc3_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [3:0] {
    OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7, OP_NOT = 4'h9,
    OP_LDI = 4'hA, OP_STI = 4'hB, OP_JMP = 4'hC, OP_LEA = 4'hE
  } opcode_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} alu_ctl_e;
  typedef enum logic [1:0] {W_ALU, W_PC, W_MEM} w_ctl_e;
  localparam int E_ALU_LO = 4;
  localparam int E_PC1_LO = 2;
  localparam int E_PC2    = 1;
  localparam int E_OP2    = 0;
  typedef struct packed {
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] pcout;
    logic [DATA_W-1:0] mdata;
    logic [2:0]        dr;
    logic [2:0]        nzp;
    logic [DATA_W-1:0] ir;
    logic [1:0]        wc;
    logic              mc;
  } exec_regs_t;
  function automatic logic [DATA_W-1:0] sext(input logic [DATA_W-1:0] v, input int w);
    return DATA_W'($signed(v << (DATA_W - w)) >>> (DATA_W - w));
  endfunction
endpackage

// File: rtl/lc3_exec_alu.sv
// lc3_exec_alu: combinational ALU and address adder of the execute stage.
module lc3_exec_alu
  import lc3_pkg::*;
(
  input  alu_ctl_e          alu_ctl,
  input  logic [1:0]        pcsel1,
  input  logic              pcsel2,
  input  logic              op2sel,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] npc,
  input  logic [10:0]       imm,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] addr
);
  logic [DATA_W-1:0] b, base, offs, immz;
  always_comb begin
    immz = DATA_W'(imm);
    b = op2sel ? op2 : sext(immz, 5);
    alu_res = alu_ctl == ALU_ADD ? op1 + b :
              alu_ctl == ALU_AND ? op1 & b :
              alu_ctl == ALU_NOT ? ~op1 : op1;
    base = pcsel2 ? npc : op1;
    offs = pcsel1 == 2'b00 ? sext(immz, 11) :
           pcsel1 == 2'b01 ? sext(immz, 9) :
           pcsel1 == 2'b10 ? sext(immz, 6) : '0;
    addr = base + offs;
  end
endmodule

// File: rtl/lc3_execute_stage.sv
// lc3_execute_stage: LC-3 execute stage with operand forwarding and a one-cycle
// pipeline register feeding memory access and writeback.
module lc3_execute_stage
  import lc3_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic [5:0]        e_control,
  input  logic [1:0]        w_control_in,
  input  logic              mem_control_in,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] VSR1,
  input  logic [DATA_W-1:0] VSR2,
  input  logic              bypass_alu_1,
  input  logic              bypass_alu_2,
  input  logic              bypass_mem_1,
  input  logic              bypass_mem_2,
  input  logic [DATA_W-1:0] mem_bypass_val,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [DATA_W-1:0] aluout,
  output logic [DATA_W-1:0] pcout,
  output logic [DATA_W-1:0] M_Data,
  output logic [2:0]        dr,
  output logic [2:0]        NZP,
  output logic [DATA_W-1:0] IR_Exec,
  output logic [1:0]        W_Control_out,
  output logic              Mem_Control_out
);
  exec_regs_t ex_d, ex_q;
  opcode_e op;
  logic [DATA_W-1:0] op1, op2, alu_res, addr;
  lc3_exec_alu u_alu (
    .alu_ctl (alu_ctl_e'(e_control[E_ALU_LO +: 2])),
    .pcsel1  (e_control[E_PC1_LO +: 2]),
    .pcsel2  (e_control[E_PC2]),
    .op2sel  (e_control[E_OP2]),
    .op1     (op1),
    .op2     (op2),
    .npc     (npc_in),
    .imm     (IR[10:0]),
    .alu_res (alu_res),
    .addr    (addr)
  );
  always_comb begin
    op = opcode_e'(IR[15:12]);
    sr1 = IR[8:6];
    sr2 = (op == OP_ST || op == OP_STR || op == OP_STI) ? IR[11:9] : IR[2:0];
    // forwarding reads the registered aluout, so no combinational loop exists
    op1 = bypass_alu_1 ? ex_q.aluout : bypass_mem_1 ? mem_bypass_val : VSR1;
    op2 = bypass_alu_2 ? ex_q.aluout : bypass_mem_2 ? mem_bypass_val : VSR2;
    ex_d.aluout = op == OP_LEA ? addr : alu_res;
    ex_d.pcout = addr;
    ex_d.mdata = op2;
    ex_d.dr = IR[11:9];
    ex_d.nzp = (op == OP_BR || op == OP_JMP) ? IR[11:9] : 3'b000;
    ex_d.ir = IR;
    ex_d.wc = w_control_in;
    ex_d.mc = mem_control_in;
  end
  always_ff @(posedge clock) begin
    if (!reset) ex_q <= '0;
    else if (enable_execute) ex_q <= ex_d;
  end
  assign aluout = ex_q.aluout;
  assign pcout = ex_q.pcout;
  assign M_Data = ex_q.mdata;
  assign dr = ex_q.dr;
  assign NZP = ex_q.nzp;
  assign IR_Exec = ex_q.ir;
  assign W_Control_out = ex_q.wc;
  assign Mem_Control_out = ex_q.mc;
endmodule

// File: tb/tb_lc3_execute_stage.sv
// tb_lc3_execute_stage: directed vector table plus reset/stall sequences for the execute stage.
module tb_lc3_execute_stage;
  logic clock = 0, reset, enable_execute, mem_control_in;
  logic [5:0] e_control;
  logic [1:0] w_control_in;
  logic [15:0] IR, npc_in, VSR1, VSR2, mem_bypass_val;
  logic bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [2:0] sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0] W_Control_out;
  logic Mem_Control_out;
  int n_vec = 0, n_err = 0;

  lc3_execute_stage dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .e_control(e_control), .w_control_in(w_control_in), .mem_control_in(mem_control_in),
    .IR(IR), .npc_in(npc_in), .VSR1(VSR1), .VSR2(VSR2),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .mem_bypass_val(mem_bypass_val), .sr1(sr1), .sr2(sr2),
    .aluout(aluout), .pcout(pcout), .M_Data(M_Data), .dr(dr), .NZP(NZP),
    .IR_Exec(IR_Exec), .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] ir, npc, vsr1, vsr2, mbv;
    logic [5:0]  ec;
    logic [3:0]  byp;
    logic [1:0]  wc;
    logic        mc;
    logic [15:0] alu, pc, md;
    logic [2:0]  dr, nzp, s1, s2;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    IR = v.ir; npc_in = v.npc; VSR1 = v.vsr1; VSR2 = v.vsr2; mem_bypass_val = v.mbv;
    e_control = v.ec; w_control_in = v.wc; mem_control_in = v.mc;
    {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = v.byp;
  endtask

  task automatic rand_inputs();
    IR = 16'($urandom); npc_in = 16'($urandom); VSR1 = 16'($urandom); VSR2 = 16'($urandom);
    mem_bypass_val = 16'($urandom); e_control = 6'($urandom); w_control_in = 2'($urandom);
    mem_control_in = 1'($urandom);
    {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = 4'($urandom);
  endtask

  task automatic chk_regs(input string tag, input vec_t v);
    chk({tag, " aluout"}, aluout, v.alu);
    chk({tag, " pcout"}, pcout, v.pc);
    chk({tag, " M_Data"}, M_Data, v.md);
    chk({tag, " dr"}, 16'(dr), 16'(v.dr));
    chk({tag, " NZP"}, 16'(NZP), 16'(v.nzp));
    chk({tag, " IR_Exec"}, IR_Exec, v.ir);
    chk({tag, " W_Control_out"}, 16'(W_Control_out), 16'(v.wc));
    chk({tag, " Mem_Control_out"}, 16'(Mem_Control_out), 16'(v.mc));
  endtask

  task automatic chk_zero(input string tag);
    vec_t z;
    z = '{default: '0};
    chk_regs(tag, z);
  endtask

  initial begin
    //         ir       npc      vsr1     vsr2     mbv      ec         byp      wc    mc    alu      pc       md       dr nzp s1 s2
    tbl[0]  = '{16'h1283,16'h0000,16'h0005,16'h0007,16'h0000,6'b000001,4'b0000,2'd0,1'b0,16'h000C,16'h0288,16'h0007,3'd1,3'd0,3'd2,3'd3};
    tbl[1]  = '{16'h1261,16'h0000,16'hFFFF,16'h1234,16'h0000,6'b000000,4'b0000,2'd1,1'b1,16'h0000,16'h0260,16'h1234,3'd1,3'd0,3'd1,3'd1};
    tbl[2]  = tbl[0];
    tbl[3]  = '{16'h1283,16'h0000,16'h0005,16'h0007,16'h0009,6'b000001,4'b1100,2'd2,1'b0,16'h0013,16'h028F,16'h0007,3'd1,3'd0,3'd2,3'd3};
    tbl[4]  = '{16'h1283,16'h0000,16'h0005,16'h0007,16'h0009,6'b000001,4'b0100,2'd0,1'b0,16'h0010,16'h028C,16'h0007,3'd1,3'd0,3'd2,3'd3};
    tbl[5]  = '{16'h5283,16'h0000,16'hF0F0,16'h0000,16'h0FF0,6'b010001,4'b0001,2'd0,1'b0,16'h00F0,16'hF373,16'h0FF0,3'd1,3'd0,3'd2,3'd3};
    tbl[6]  = '{16'h927F,16'h0000,16'h00FF,16'h0000,16'hAAAA,6'b100000,4'b0011,2'd0,1'b0,16'hFF00,16'h037E,16'h00F0,3'd1,3'd0,3'd1,3'd7};
    tbl[7]  = '{16'h0A05,16'h3001,16'h0000,16'h0000,16'h0000,6'b000110,4'b0000,2'd0,1'b0,16'h0005,16'h3006,16'h0000,3'd5,3'd5,3'd0,3'd5};
    tbl[8]  = '{16'hE5FF,16'h3001,16'h1111,16'h0000,16'h0000,6'b000110,4'b0000,2'd0,1'b0,16'h3000,16'h3000,16'h0000,3'd2,3'd0,3'd7,3'd7};
    tbl[9]  = '{16'h773E,16'h0000,16'h4000,16'hBEEF,16'h0000,6'b001001,4'b0000,2'd2,1'b1,16'hFEEF,16'h3FFE,16'hBEEF,3'd3,3'd0,3'd4,3'd3};
    tbl[10] = '{16'hC140,16'h0000,16'h5A5A,16'h0001,16'h0000,6'b111101,4'b0000,2'd0,1'b0,16'h5A5A,16'h5A5A,16'h0001,3'd0,3'd0,3'd5,3'd0};
    tbl[11] = '{16'h05FD,16'h3000,16'h0000,16'h0000,16'h0000,6'b000110,4'b0000,2'd0,1'b0,16'hFFFD,16'h2FFD,16'h0000,3'd2,3'd2,3'd7,3'd5};
    tbl[12] = '{16'h4FFF,16'h3000,16'h0000,16'h0000,16'h0000,6'b000010,4'b0000,2'd0,1'b0,16'hFFFF,16'h2FFF,16'h0000,3'd7,3'd0,3'd7,3'd7};
    tbl[13] = '{16'h3C02,16'h3000,16'h0010,16'h00AB,16'h0000,6'b000111,4'b0000,2'd0,1'b1,16'h00BB,16'h3002,16'h00AB,3'd6,3'd0,3'd0,3'd6};
    tbl[14] = '{16'hB3FF,16'h3000,16'h0000,16'h0055,16'h0000,6'b000110,4'b0000,2'd0,1'b0,16'hFFFF,16'h2FFF,16'h0055,3'd1,3'd0,3'd7,3'd1};

    reset = 0; enable_execute = 1;
    rand_inputs();
    repeat (2) begin
      @(negedge clock); rand_inputs();
    end
    @(posedge clock); #1;
    chk_zero("reset");
    @(negedge clock); reset = 1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d sr1", i), 16'(sr1), 16'(tbl[i].s1));
      chk($sformatf("v%0d sr2", i), 16'(sr2), 16'(tbl[i].s2));
      @(posedge clock); #1;
      chk_regs($sformatf("v%0d", i), tbl[i]);
      @(negedge clock);
    end

    drive(tbl[0]);
    @(posedge clock); #1;
    chk("stall preload aluout", aluout, 16'h000C);
    @(negedge clock);
    enable_execute = 0;
    for (int k = 0; k < 3; k++) begin
      drive(tbl[9 + k]);
      #1;
      chk($sformatf("stall%0d sr1", k), 16'(sr1), 16'(tbl[9 + k].s1));
      @(posedge clock); #1;
      chk_regs($sformatf("stall%0d", k), tbl[0]);
      @(negedge clock);
    end

    enable_execute = 1; reset = 0;
    drive(tbl[7]);
    @(posedge clock); #1;
    chk_zero("midreset");
    @(negedge clock); reset = 1;
    drive(tbl[8]);
    @(posedge clock); #1;
    chk_regs("post-reset", tbl[8]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
